ureg_nbit: RTL

UREG_NBIT -- requirements
Module: ureg_nbit

---
 rtl/ureg_pkg.sv | 17 +
 rtl/ureg_nbit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ureg_pkg.sv
// Shared encodings for ureg_nbit: operation modes and sequencer states.
package ureg_pkg;

  typedef enum logic [1:0] {
    SL = 2'b00,
    SR = 2'b01,
    RL = 2'b10,
    RR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/ureg_nbit.sv
// Universal N-bit register: parallel load plus multi-cycle shift/rotate sequences.
// Optional build macro UREG_PARITY_EN adds a combinational parity output.
module ureg_nbit
  import ureg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pl,
  input  logic [WIDTH-1:0]   in,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sin,
  output logic [WIDTH-1:0]   out,
  output logic               sout,
  output logic               busy,
  output logic               done
`ifdef UREG_PARITY_EN
  ,
  output logic               parity
`endif
);

  // Handshake: start is a level request sampled only in IDLE (pl has priority);
  // busy is high for every cycle spent shifting and done pulses for exactly one
  // cycle when the sequence finishes. pl/start are ignored while busy or done.

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_d;
  logic               sout_d;
  logic [SHAMT_W-1:0] shamt_sat;

  assign shamt_sat = (shamt > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : shamt;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    out_d   = out;
    sout_d  = sout;
    unique case (state_q)
      IDLE: begin
        if (pl) begin
          out_d = in;
        end else if (start) begin
          if (shamt == '0) begin
            state_d = DONE;
          end else begin
            mode_d  = mode_t'(mode);
            cnt_d   = shamt_sat;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // sin is taken live on each shift edge; mode and count were frozen at start
        unique case (mode_q)
          SL: begin
            out_d  = {out[WIDTH-2:0], sin};
            sout_d = out[WIDTH-1];
          end
          SR: begin
            out_d  = {sin, out[WIDTH-1:1]};
            sout_d = out[0];
          end
          RL: begin
            out_d  = {out[WIDTH-2:0], out[WIDTH-1]};
            sout_d = out[WIDTH-1];
          end
          RR: begin
            out_d  = {out[0], out[WIDTH-1:1]};
            sout_d = out[0];
          end
          default: begin
            out_d  = out;
            sout_d = sout;
          end
        endcase
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= SL;
      cnt_q   <= '0;
      out     <= '0;
      sout    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      sout    <= sout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

`ifdef UREG_PARITY_EN
  assign parity = ^out;
`endif

endmodule
